// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: decodes per-stage load enables, IF/ID flush and ID/EX bubble
// from a small run/stall/drain FSM. Enables are combinational on state and inputs.
// Optional performance counters are built when PIPE_SEQ_PERF_CNT_EN is defined;
// otherwise stall_count and kill_count read constant zero.
module pipe_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        Stall,
  input  logic        KILL,
  input  logic        halt_req,
  input  logic        mem_busy,
  output logic        en_PC,
  output logic        en_IFID,
  output logic        flush_IFID,
  output logic        en_IDEX,
  output logic        bubble_IDEX,
  output logic        en_EXMEM,
  output logic        en_MEMWB,
  output logic        running,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] kill_count
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StMemWait = 3'd2,
    StDrain   = 3'd3,
    StHalted  = 3'd4
  } state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [1:0] r_drain_cnt;
  logic [1:0] w_drain_next;

  logic w_en_pc;
  logic w_en_ifid;
  logic w_flush_ifid;
  logic w_en_idex;
  logic w_bubble_idex;
  logic w_en_exmem;
  logic w_en_memwb;

  // Next-state and enable decode; everything defaults to a frozen pipeline.
  always_comb begin
    w_state_next  = r_state;
    w_drain_next  = r_drain_cnt;
    w_en_pc       = 1'b0;
    w_en_ifid     = 1'b0;
    w_flush_ifid  = 1'b0;
    w_en_idex     = 1'b0;
    w_bubble_idex = 1'b0;
    w_en_exmem    = 1'b0;
    w_en_memwb    = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) w_state_next = StRun;
      end
      // MEMWAIT with memory ready decodes exactly like RUN.
      StRun, StMemWait: begin
        if (mem_busy) begin
          w_state_next = StMemWait;
        end else begin
          w_state_next = StRun;
          w_en_idex    = 1'b1;
          w_en_exmem   = 1'b1;
          w_en_memwb   = 1'b1;
          if (Stall) begin
            w_bubble_idex = 1'b1;
          end else if (halt_req) begin
            w_en_ifid    = 1'b1;
            w_flush_ifid = 1'b1;
            w_state_next = StDrain;
            w_drain_next = 2'd3;
          end else if (KILL) begin
            w_en_pc      = 1'b1;
            w_en_ifid    = 1'b1;
            w_flush_ifid = 1'b1;
          end else begin
            w_en_pc   = 1'b1;
            w_en_ifid = 1'b1;
          end
        end
      end
      // Push NOPs through the pipe until the halt has retired; memory stalls freeze it.
      StDrain: begin
        if (!mem_busy) begin
          w_en_ifid     = 1'b1;
          w_flush_ifid  = 1'b1;
          w_en_idex     = 1'b1;
          w_bubble_idex = 1'b1;
          w_en_exmem    = 1'b1;
          w_en_memwb    = 1'b1;
          if (r_drain_cnt <= 2'd1) begin
            w_drain_next = 2'd0;
            w_state_next = StHalted;
          end else begin
            w_drain_next = r_drain_cnt - 2'd1;
          end
        end
      end
      StHalted: begin
        if (start) w_state_next = StRun;
      end
      default: begin
        w_state_next = StIdle;
        w_drain_next = 2'd0;
      end
    endcase
  end

  // State and drain counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  // Outputs forced quiet while reset is asserted, even before the first edge.
  assign en_PC       = rst_n & w_en_pc;
  assign en_IFID     = rst_n & w_en_ifid;
  assign flush_IFID  = rst_n & w_flush_ifid;
  assign en_IDEX     = rst_n & w_en_idex;
  assign bubble_IDEX = rst_n & w_bubble_idex;
  assign en_EXMEM    = rst_n & w_en_exmem;
  assign en_MEMWB    = rst_n & w_en_memwb;
  assign running     = rst_n & (r_state == StRun);
  assign halted      = rst_n & (r_state == StHalted);
  assign state       = r_state;

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic        w_live;
  logic        w_stall_evt;
  logic        w_kill_evt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_kill_cnt;

  assign w_live      = ((r_state == StRun) || (r_state == StMemWait)) && !mem_busy;
  assign w_stall_evt = w_live && Stall;
  // Only a KILL-caused flush counts; a halt flush does not.
  assign w_kill_evt  = w_live && !Stall && !halt_req && KILL;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
      r_kill_cnt  <= 16'd0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_kill_evt && (r_kill_cnt != 16'hFFFF))   r_kill_cnt  <= r_kill_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign kill_count  = r_kill_cnt;
`else
  assign stall_count = 16'd0;
  assign kill_count  = 16'd0;
`endif

endmodule
